// File: rtl/ula_seq.sv
// Registered, handshaked ALU: single-cycle arithmetic/logic ops plus iterative MUL/DIV.
// Optional macro ULA_MULDIV_EN enables the multi-cycle MUL/DIV datapath and BUSY state.
module ula_seq #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carrier_flag,
  output logic             negative_flag
);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SHL = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SHR = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MOV = OP_W'(4);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(5);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(7);

  logic             accept;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic             sc_neg;
  logic             wr_en;
  logic [WIDTH-1:0] wr_res;
  logic             wr_carry;
  logic             wr_neg;

  assign accept = in_valid && in_ready;

  // Single-cycle ops; MUL/DIV codes fall into the illegal-op default here.
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_neg   = 1'b0;
    case (op)
      OP_ADD: {sc_carry, sc_res} = {1'b0, val_a} + {1'b0, val_b};
      OP_SUB: begin
        sc_res   = val_a - val_b;
        sc_carry = (val_b > val_a);
        sc_neg   = (val_b > val_a);
      end
      OP_SHL: begin
        sc_res   = {val_a[WIDTH-2:0], 1'b0};
        sc_carry = val_a[WIDTH-1];
      end
      OP_SHR: begin
        sc_res   = {1'b0, val_a[WIDTH-1:1]};
        sc_carry = val_a[0];
      end
      OP_MOV:  sc_res = val_b;
      OP_AND:  sc_res = val_a & val_b;
      OP_OR:   sc_res = val_a | val_b;
      OP_XOR:  sc_res = val_a ^ val_b;
      default: sc_res = '0;
    endcase
  end

`ifdef ULA_MULDIV_EN
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(8);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(9);
  localparam int              CW     = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      count;
  logic               is_md_op;
  logic               last;
  logic               is_div;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   quot_nxt;
  logic [WIDTH-1:0]   divisor;

  assign is_md_op = (op == OP_MUL) || (op == OP_DIV);
  assign last     = (state == BUSY) && (count == CW'(1));
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_md_op) state_nxt = BUSY;
      BUSY:    if (count == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One shift-add step and one restoring-division step per BUSY edge.
  // A zero divisor always passes the compare, so the quotient fills with ones.
  always_comb begin
    acc_nxt = mplr[0] ? (acc + mcand) : acc;
    rem_sh  = {rem, quot[WIDTH-1]};
    if (rem_sh >= {1'b0, divisor}) begin
      rem_nxt  = WIDTH'(rem_sh - {1'b0, divisor});
      quot_nxt = {quot[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt  = rem_sh[WIDTH-1:0];
      quot_nxt = {quot[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      is_div  <= 1'b0;
      mcand   <= '0;
      acc     <= '0;
      mplr    <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
    end else if (accept && is_md_op) begin
      count   <= CW'(WIDTH);
      is_div  <= (op == OP_DIV);
      mcand   <= {{WIDTH{1'b0}}, val_a};
      acc     <= '0;
      mplr    <= val_b;
      rem     <= '0;
      quot    <= val_a;
      divisor <= val_b;
    end else if (state == BUSY) begin
      count <= count - CW'(1);
      mcand <= {mcand[2*WIDTH-2:0], 1'b0};
      mplr  <= {1'b0, mplr[WIDTH-1:1]};
      acc   <= acc_nxt;
      rem   <= rem_nxt;
      quot  <= quot_nxt;
    end
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_res   = sc_res;
    wr_carry = sc_carry;
    wr_neg   = sc_neg;
    if (accept && !is_md_op) begin
      wr_en = 1'b1;
    end else if (last) begin
      wr_en  = 1'b1;
      wr_neg = 1'b0;
      if (is_div) begin
        wr_res   = quot_nxt;
        wr_carry = (divisor == '0);
      end else begin
        wr_res   = acc_nxt[WIDTH-1:0];
        wr_carry = |acc_nxt[2*WIDTH-1:WIDTH];
      end
    end
  end
`else
  assign in_ready = 1'b1;

  always_comb begin
    wr_en    = accept;
    wr_res   = sc_res;
    wr_carry = sc_carry;
    wr_neg   = sc_neg;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      result        <= '0;
      zero_flag     <= 1'b1;
      carrier_flag  <= 1'b0;
      negative_flag <= 1'b0;
    end else begin
      out_valid <= wr_en;
      if (wr_en) begin
        result        <= wr_res;
        zero_flag     <= (wr_res == '0);
        carrier_flag  <= wr_carry;
        negative_flag <= wr_neg;
      end
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Directed-vector bench for ula_seq (WIDTH=8, OP_W=4); MUL/DIV cases follow ULA_MULDIV_EN.
module tb_ula_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] val_a;
  logic [7:0] val_b;
  logic [3:0] op;
  logic       out_valid;
  logic [7:0] result;
  logic       zero_flag;
  logic       carrier_flag;
  logic       negative_flag;

  int n_checks = 0;
  int n_pass   = 0;

  ula_seq #(.WIDTH(8), .OP_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .val_a        (val_a),
    .val_b        (val_b),
    .op           (op),
    .out_valid    (out_valid),
    .result       (result),
    .zero_flag    (zero_flag),
    .carrier_flag (carrier_flag),
    .negative_flag(negative_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Present one op at the next negedge, let it be accepted, then check the registered outputs.
  task automatic do_single(input string tag, input logic [3:0] o, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] er, input logic ez,
                           input logic ec, input logic en);
    @(negedge clk);
    in_valid = 1'b1; op = o; val_a = a; val_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".ovalid"}, 32'(out_valid), 32'(1));
    check({tag, ".res"}, 32'(result), 32'(er));
    check({tag, ".zero"}, 32'(zero_flag), 32'(ez));
    check({tag, ".carry"}, 32'(carrier_flag), 32'(ec));
    check({tag, ".neg"}, 32'(negative_flag), 32'(en));
  endtask

  task automatic do_multi(input string tag, input logic [3:0] o, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er, input logic ec);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; op = o; val_a = a; val_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(8));
    check({tag, ".res"}, 32'(result), 32'(er));
    check({tag, ".zero"}, 32'(zero_flag), 32'(er == 8'd0));
    check({tag, ".carry"}, 32'(carrier_flag), 32'(ec));
    check({tag, ".ready"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; val_a = '0; val_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.res", 32'(result), 32'(0));
    check("rst.zero", 32'(zero_flag), 32'(1));
    check("rst.carry", 32'(carrier_flag), 32'(0));
    check("rst.neg", 32'(negative_flag), 32'(0));
    check("rst.ovalid", 32'(out_valid), 32'(0));
    check("rst.ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;

    do_single("add_ovf", 4'd0, 8'd200, 8'd100, 8'd44, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("add_ovf.pulse_end", 32'(out_valid), 32'(0));
    check("add_ovf.hold", 32'(result), 32'(44));
    do_single("add_zero", 4'd0, 8'd128, 8'd128, 8'd0, 1'b1, 1'b1, 1'b0);
    do_single("sub_neg", 4'd1, 8'd3, 8'd5, 8'd254, 1'b0, 1'b1, 1'b1);
    do_single("sub_eq", 4'd1, 8'd5, 8'd5, 8'd0, 1'b1, 1'b0, 1'b0);
    do_single("shr", 4'd3, 8'h81, 8'h00, 8'h40, 1'b0, 1'b1, 1'b0);
    do_single("shl", 4'd2, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0);
    do_single("and", 4'd5, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    do_single("or", 4'd6, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0);

    // Back-to-back accepts on consecutive edges.
    do_single("b2b_add", 4'd0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0);
    do_single("b2b_xor", 4'd7, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0);
    do_single("b2b_mov", 4'd4, 8'h55, 8'd7, 8'd7, 1'b0, 1'b0, 1'b0);
    do_single("illegal", 4'd15, 8'd9, 8'd9, 8'd0, 1'b1, 1'b0, 1'b0);

`ifdef ULA_MULDIV_EN
    // MUL with an ADD held on in_valid throughout BUSY.
    @(negedge clk);
    in_valid = 1'b1; op = 4'd8; val_a = 8'd20; val_b = 8'd15;
    @(posedge clk); #1;
    check("mul.busy0_ready", 32'(in_ready), 32'(0));
    op = 4'd0; val_a = 8'd1; val_b = 8'd1;
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("mul.busy%0d_ready", k), 32'(in_ready), 32'(0));
      check($sformatf("mul.busy%0d_ovalid", k), 32'(out_valid), 32'(0));
    end
    @(posedge clk); #1;
    check("mul.ovalid", 32'(out_valid), 32'(1));
    check("mul.res", 32'(result), 32'(44));
    check("mul.carry", 32'(carrier_flag), 32'(1));
    check("mul.ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("held_add.ovalid", 32'(out_valid), 32'(1));
    check("held_add.res", 32'(result), 32'(2));

    do_multi("div", 4'd9, 8'd100, 8'd7, 8'd14, 1'b0);
    do_multi("div0", 4'd9, 8'd5, 8'd0, 8'd255, 1'b1);
    do_multi("mul_small", 4'd8, 8'd3, 8'd4, 8'd12, 1'b0);

    // Reset during the 4th BUSY cycle aborts the MUL.
    @(negedge clk);
    in_valid = 1'b1; op = 4'd8; val_a = 8'd255; val_b = 8'd255;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort.ovalid", 32'(out_valid), 32'(0));
    check("abort.res", 32'(result), 32'(0));
    check("abort.zero", 32'(zero_flag), 32'(1));
    check("abort.ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort.quiet%0d", k), 32'(out_valid), 32'(0));
    end
    do_single("after_abort", 4'd0, 8'd10, 8'd5, 8'd15, 1'b0, 1'b0, 1'b0);
`else
    do_single("mul_off", 4'd8, 8'd20, 8'd15, 8'd0, 1'b1, 1'b0, 1'b0);
    check("mul_off.ready", 32'(in_ready), 32'(1));
    do_single("div_off", 4'd9, 8'd5, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
`endif

    @(posedge clk); #1;
    check("final.ovalid", 32'(out_valid), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
